// File: rtl/sqrt_iter_unit_if.sv
// Start/busy/done handshake and result bus of the square-root unit.
// master: requester side; slave: sqrt_iter_unit. remainder_o with SQRT_REMAINDER_EN.
interface sqrt_iter_unit_if #(
  parameter int DATA_W = 32
);
  localparam int ROOT_W = DATA_W / 2;

  logic              start_i;
  logic [DATA_W-1:0] radicand_i;
  logic              busy_o;
  logic              done_o;
  logic [ROOT_W-1:0] root_o;
`ifdef SQRT_REMAINDER_EN
  logic [ROOT_W:0]   remainder_o;
`endif

  modport master (
    output start_i,
    output radicand_i,
    input  busy_o,
    input  done_o,
`ifdef SQRT_REMAINDER_EN
    input  remainder_o,
`endif
    input  root_o
  );

  modport slave (
    input  start_i,
    input  radicand_i,
    output busy_o,
    output done_o,
`ifdef SQRT_REMAINDER_EN
    output remainder_o,
`endif
    output root_o
  );
endinterface

// File: rtl/sqrt_iter_unit.sv
// Restoring digit-by-digit integer square root, one root bit per clock.
// Ports: clk_i, rst_i (async high), bus (slave). Macro SQRT_REMAINDER_EN adds remainder_o.
module sqrt_iter_unit #(
  parameter int DATA_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sqrt_iter_unit_if.slave bus
);
  localparam int ROOT_W = DATA_W / 2;
  localparam int CNT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] DONE_S = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] d;
  logic [ROOT_W+1:0] r;
  logic [ROOT_W-1:0] q;
  logic [CNT_W-1:0]  cnt;
  logic [ROOT_W-1:0] root_q;
`ifdef SQRT_REMAINDER_EN
  logic [ROOT_W:0]   rem_q;
`endif

  logic [ROOT_W+3:0] s_w;
  logic [ROOT_W+3:0] t_w;
  logic [ROOT_W+3:0] diff_w;
  logic              lt;
  logic [ROOT_W+1:0] r_nxt;
  logic [ROOT_W-1:0] q_nxt;
  logic              unused_bits;

  // Full-width compare; the upper two bits of S are always zero
  // because R never exceeds 2*Q, so this equals the narrow compare.
  assign s_w    = {r, d[DATA_W-1 -: 2]};
  assign t_w    = {2'b00, q, 2'b01};
  assign lt     = s_w < t_w;
  assign diff_w = s_w - t_w;
  assign r_nxt  = lt ? s_w[ROOT_W+1:0]
                     : diff_w[ROOT_W+1:0];
  assign q_nxt  = {q[ROOT_W-2:0], ~lt};

  assign unused_bits = ^{s_w[ROOT_W+3:ROOT_W+2],
                         diff_w[ROOT_W+3:ROOT_W+2],
                         r_nxt[ROOT_W+1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      d      <= '0;
      r      <= '0;
      q      <= '0;
      cnt    <= '0;
      root_q <= '0;
`ifdef SQRT_REMAINDER_EN
      rem_q  <= '0;
`endif
    end else begin
      unique case (1'b1)
        (state == RUN): begin
          d <= d << 2;
          r <= r_nxt;
          q <= q_nxt;
          if (cnt == '0) begin
            state  <= DONE_S;
            root_q <= q_nxt;
`ifdef SQRT_REMAINDER_EN
            rem_q  <= r_nxt[ROOT_W:0];
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        (state == IDLE),
        (state == DONE_S): begin
          if (bus.start_i) begin
            d     <= bus.radicand_i;
            r     <= '0;
            q     <= '0;
            cnt   <= CNT_W'(ROOT_W - 1);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = (state == RUN);
  assign bus.done_o = (state == DONE_S);
  assign bus.root_o = root_q;
`ifdef SQRT_REMAINDER_EN
  assign bus.remainder_o = rem_q;
`endif
endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Directed bench for sqrt_iter_unit (DATA_W=32).
// Remainder checks active when SQRT_REMAINDER_EN is defined.
module tb_sqrt_iter_unit;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  int   done_cnt;
  int   lat;
  int   t_first;
  int   cyc;
  int   d0;

  sqrt_iter_unit_if #(.DATA_W(32)) bus ();

  sqrt_iter_unit #(.DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_excl",
            64'(bus.busy_o & bus.done_o), 64'd0);
      if (bus.done_o) done_cnt++;
    end
  end

  task automatic chk_res(input string tag,
                         input logic [15:0] root,
                         input logic [16:0] rem);
    check({tag, "_root"}, 64'(bus.root_o), 64'(root));
`ifdef SQRT_REMAINDER_EN
    check({tag, "_rem"}, 64'(bus.remainder_o), 64'(rem));
`else
    if (rem == 17'h1ffff) $display("unreachable");
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic start_op(input logic [31:0] val);
    bus.start_i    = 1'b1;
    bus.radicand_i = val;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!bus.done_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done_o) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] val,
                        input logic [15:0] root,
                        input logic [16:0] rem);
    start_op(val);
    check({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
    wait_done(tag, lat);
    check({tag, "_lat"}, 64'(lat), 64'd16);
    chk_res(tag, root, rem);
    @(posedge clk);
    #1;
    check({tag, "_done_drop"}, 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    done_cnt = 0;
    cyc = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.radicand_i = '0;
    #3;
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    chk_res("rst", 16'd0, 17'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("r0", 32'd0, 16'd0, 17'd0);
    run_op("r17", 32'd17, 16'd4, 17'd1);
    run_op("r1e6", 32'd1000000, 16'd1000, 17'd0);
    run_op("rmax", 32'hffffffff, 16'hffff, 17'h1fffe);

    // start during RUN must be ignored
    d0 = done_cnt;
    start_op(32'd144);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.start_i = 1'b1;
    bus.radicand_i = 32'd9;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    check("ign_root_hold", 64'(bus.root_o), 64'hffff);
    wait_done("ign", lat);
    check("ign_lat", 64'(lat), 64'd11);
    chk_res("ign", 16'd12, 17'd0);
    repeat (20) @(posedge clk);
    #1;
    check("ign_one_done", 64'(done_cnt - d0), 64'd1);

    // reset mid-operation
    start_op(32'd99);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("mid_busy", 64'(bus.busy_o), 64'd0);
    check("mid_done", 64'(bus.done_o), 64'd0);
    chk_res("mid", 16'd0, 17'd0);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_no_done", 64'(done_cnt - d0), 64'd0);
    check("mid_idle", 64'(bus.busy_o), 64'd0);
    run_op("r99", 32'd99, 16'd9, 17'd18);

    // back-to-back
    start_op(32'd50);
    wait_done("b2b1", lat);
    check("b2b1_lat", 64'(lat), 64'd16);
    chk_res("b2b1", 16'd7, 17'd1);
    t_first = cyc;
    start_op(32'd81);
    check("b2b_done_drop", 64'(bus.done_o), 64'd0);
    check("b2b_busy", 64'(bus.busy_o), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk_res("b2b_hold", 16'd7, 17'd1);
    wait_done("b2b2", lat);
    check("b2b_gap", 64'(cyc - t_first), 64'd17);
    chk_res("b2b2", 16'd9, 17'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
